// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands one bit per cycle,
// LSB first, through a single full-add cell and a carry flip-flop.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic [1:0]       state_dbg
);

  // Counter must be able to hold WIDTH so an overrun can be detected.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry_q;
  logic [CW-1:0]    cnt;

  logic ha1_s, ha1_c, ha2_c, fa_s, fa_c;

  // Full-add cell: two half-add stages with their carries ORed together.
  assign ha1_s = a_sr[0] ^ b_sr[0];
  assign ha1_c = a_sr[0] & b_sr[0];
  assign fa_s  = ha1_s ^ carry_q;
  assign ha2_c = ha1_s & carry_q;
  assign fa_c  = ha1_c | ha2_c;

  assign state_dbg = state;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy_out <= 1'b0;
          done_out <= 1'b0;
          if (start_in) begin
            state     <= RUN;
            busy_out  <= 1'b1;
            a_sr      <= a_in;
            b_sr      <= b_in;
            carry_q   <= 1'b0;
            cnt       <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
          end
        end
        RUN: begin
          if (cnt >= CW'(WIDTH)) begin
            // Overrun guard: never write outside sum_out, just finish.
            state    <= DONE;
            done_out <= 1'b1;
          end else begin
            for (int i = 0; i < WIDTH; i++) begin
              if (cnt == CW'(i)) sum_out[i] <= fa_s;
            end
            carry_q <= fa_c;
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            cnt     <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              state     <= DONE;
              done_out  <= 1'b1;
              carry_out <= fa_c;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          busy_out <= 1'b0;
          done_out <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
          done_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
